// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine
// Computes C = A x B (mode 0) or C = C + A x B (mode 1) for unsigned NxN matrices,
// one multiply-accumulate per cycle through a single shared MAC.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   wr_en, wr_sel        operand write strobe; 0 selects A, 1 selects B
//   wr_row, wr_col       operand indices (out-of-range writes are dropped)
//   wr_data              operand value
//   start, mode          start pulse (IDLE only) and accumulate mode, sampled together
//   rd_row, rd_col       result indices (out-of-range reads return 0)
//   rd_data              registered C[rd_row][rd_col]
//   busy, done           operation in progress / one-cycle completion pulse
//   ovf                  sticky overflow of the last operation
//   op_count             completed operations, wraps at 8 bits
module matrix_mac_engine #(
    parameter int unsigned N   = 4,
    parameter int unsigned DW  = 8,
    parameter int unsigned RW  = 18,
    parameter int unsigned SAT = 0,
    localparam int unsigned AW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_row,
    input  logic [AW-1:0] wr_col,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] rd_row,
    input  logic [AW-1:0] rd_col,
    output logic [RW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic [7:0]    op_count
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StMac   = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [AW:0]   NumEl   = (AW + 1)'(N);
    localparam logic [AW-1:0] LastIdx = AW'(N - 1);

    logic [DW-1:0] a_mem [N][N];
    logic [DW-1:0] b_mem [N][N];
    logic [RW-1:0] c_mem [N][N];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] i_q, j_q, k_q;
    logic [RW:0]   acc_q;
    logic          mode_q;
    logic          ovf_q;
    logic [7:0]    op_count_q;
    logic [RW-1:0] rd_data_q;

    logic [2*DW-1:0] prod;
    logic [RW:0]     r_sum;
    logic [RW-1:0]   c_val;
    logic            last_elem;
    logic            wr_in_range;
    logic            rd_in_range;

    assign prod        = a_mem[i_q][k_q] * b_mem[k_q][j_q];
    // Accumulate mode adds the old C element at RW+1 bits so bit RW flags overflow.
    assign r_sum       = acc_q + (mode_q ? {1'b0, c_mem[i_q][j_q]} : '0);
    assign last_elem   = (i_q == LastIdx) && (j_q == LastIdx);
    assign wr_in_range = ({1'b0, wr_row} < NumEl) && ({1'b0, wr_col} < NumEl);
    assign rd_in_range = ({1'b0, rd_row} < NumEl) && ({1'b0, rd_col} < NumEl);

    always_comb begin
        c_val = r_sum[RW-1:0];
        if (r_sum[RW] && (SAT != 0)) begin
            c_val = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StMac;
            StMac:   if (k_q == LastIdx) state_d = StWrite;
            StWrite: state_d = last_elem ? StDone : StMac;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            mode_q     <= 1'b0;
            ovf_q      <= 1'b0;
            op_count_q <= '0;
            rd_data_q  <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                    c_mem[r][c] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_in_range ? c_mem[rd_row][rd_col] : '0;
            unique case (state_q)
                StIdle: begin
                    if (wr_en && wr_in_range) begin
                        if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
                        else        a_mem[wr_row][wr_col] <= wr_data;
                    end
                    if (start) begin
                        mode_q <= mode;
                        ovf_q  <= 1'b0;
                        i_q    <= '0;
                        j_q    <= '0;
                        k_q    <= '0;
                        acc_q  <= '0;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + (RW + 1)'(prod);
                    k_q   <= (k_q == LastIdx) ? '0 : k_q + 1'b1;
                end
                StWrite: begin
                    c_mem[i_q][j_q] <= c_val;
                    if (r_sum[RW]) ovf_q <= 1'b1;
                    acc_q <= '0;
                    if (j_q == LastIdx) begin
                        j_q <= '0;
                        i_q <= (i_q == LastIdx) ? '0 : i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                StDone: op_count_q <= op_count_q + 8'd1;
                default: ;
            endcase
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign ovf      = ovf_q;
    assign op_count = op_count_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
module tb_matrix_mac_engine;

    localparam int N   = 4;
    localparam int RW  = 18;
    localparam int SAT = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, wr_sel, start, mode;
    logic [1:0]  wr_row, wr_col, rd_row, rd_col;
    logic [7:0]  wr_data;
    logic [17:0] rd_data, rd3;
    logic        busy, done, ovf, busy3, done3, ovf3;
    logic [7:0]  op_count, op_count3;

    always #5 clk = ~clk;

    matrix_mac_engine #(.N(4), .DW(8), .RW(18), .SAT(SAT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .start(start), .mode(mode),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .busy(busy),
        .done(done), .ovf(ovf), .op_count(op_count)
    );

    // Second build with N=3 shares all inputs; used for out-of-range reads.
    matrix_mac_engine #(.N(3), .DW(8), .RW(18), .SAT(SAT)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .start(start), .mode(mode),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd3), .busy(busy3),
        .done(done3), .ovf(ovf3), .op_count(op_count3)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int ma [4][4];
    int mb [4][4];
    int mc [4][4];
    int m_ovf = 0;
    int m_opc = 0;
    int sb [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input int r, input int c, input int d);
        wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = 8'(d);
        tick();
        wr_en = 1'b0;
        if (sel) mb[r][c] = d;
        else     ma[r][c] = d;
    endtask

    task automatic model_op(input int m);
        int s;
        m_ovf = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
                if (m != 0) s += mc[i][j];
                if (s >= (1 << RW)) begin
                    m_ovf = 1;
                    s = (SAT != 0) ? (1 << RW) - 1 : s - (1 << RW);
                end
                mc[i][j] = s;
            end
        end
        m_opc = (m_opc + 1) % 256;
    endtask

    // Scoreboard read: expectation queued when the address is driven, checked next cycle.
    task automatic rd(input string tag, input int r, input int c, input int exp,
                      input bit use3);
        int e;
        rd_row = 2'(r); rd_col = 2'(c);
        sb.push_back(exp);
        tick();
        e = sb.pop_front();
        chk(tag, use3 ? int'(rd3) : int'(rd_data), e);
    endtask

    task automatic rd_all(input string tag);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) rd(tag, r, c, mc[r][c], 1'b0);
    endtask

    task automatic run_op(input logic m, input bit inject, input bit timing);
        int ndone;
        ndone = 0;
        start = 1'b1; mode = m;
        tick();
        start = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (timing) begin
                chk("busy_timing", int'(busy), int'(t <= 80));
                chk("done_timing", int'(done), int'(t == 80));
            end
            if (done) ndone++;
            if (!busy) break;
            if (inject && (t == 10 || t == 40)) begin
                start = 1'b1; mode = 1'b1;
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd7;
            end
            tick();
            start = 1'b0; wr_en = 1'b0;
        end
        chk("done_pulses", ndone, 1);
        chk("op_finished", int'(busy), 0);
        model_op(int'(m));
    endtask

    task automatic load_ident_pattern();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, (r == c) ? 1 : 0);
                wr(1'b1, r, c, 4 * r + c);
            end
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; wr_sel = 0; start = 0; mode = 0;
        wr_row = 0; wr_col = 0; wr_data = 0; rd_row = 0; rd_col = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin ma[r][c] = 0; mb[r][c] = 0; mc[r][c] = 0; end
        tick(); tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_op_count", int'(op_count), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        rst = 1'b0;
        tick();

        // N=3 build: A=I, B[r][c]=3r+c+1, then out-of-range reads return 0.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                wr(1'b0, r, c, (r == c) ? 1 : 0);
                wr(1'b1, r, c, 3 * r + c + 1);
            end
        run_op(1'b0, 1'b0, 1'b0);
        rd("n3_c00", 0, 0, 1, 1'b1);
        rd("n3_row3", 3, 0, 0, 1'b1);
        rd("n3_c12", 1, 2, 6, 1'b1);
        rd("n3_col3", 0, 3, 0, 1'b1);
        rd("n3_c22", 2, 2, 9, 1'b1);
        rd("n3_c33", 3, 3, 0, 1'b1);
        rd("n3_c21", 2, 1, 8, 1'b1);

        // Identity times pattern with done/busy timing.
        load_ident_pattern();
        run_op(1'b0, 1'b0, 1'b1);
        rd_all("ident_c");
        chk("ident_ovf", int'(ovf), m_ovf);
        chk("ident_op_count", int'(op_count), m_opc);

        // All 255, overwrite mode.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin wr(1'b0, r, c, 255); wr(1'b1, r, c, 255); end
        run_op(1'b0, 1'b0, 1'b0);
        rd_all("full_c");
        rd("full_c_const", 2, 3, 260100, 1'b0);
        chk("full_ovf", int'(ovf), 0);
        chk("full_op_count", int'(op_count), m_opc);

        // Accumulate mode overflows.
        run_op(1'b1, 1'b0, 1'b0);
        rd_all("acc_c");
        rd("acc_c_const", 1, 1, (SAT != 0) ? 262143 : 258056, 1'b0);
        chk("acc_ovf", int'(ovf), 1);
        chk("acc_ovf_model", int'(ovf), m_ovf);

        // start/wr_en during busy are ignored.
        load_ident_pattern();
        run_op(1'b0, 1'b1, 1'b0);
        rd_all("ignore_c");
        chk("ignore_ovf", int'(ovf), 0);
        chk("ignore_op_count", int'(op_count), m_opc);
        tick(); tick();
        chk("ignore_no_restart", int'(busy), 0);

        // Reset in the middle of an operation.
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        for (int t = 0; t < 30; t++) tick();
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_op_count", int'(op_count), 0);
        chk("midrst_ovf", int'(ovf), 0);
        tick();
        rst = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mc[r][c] = 0;
        rd("midrst_c00", 0, 0, 0, 1'b0);
        rd("midrst_c33", 3, 3, 0, 1'b0);
        rd("midrst_c12", 1, 2, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
